// File: rtl/tx_ctrl_sys.sv
// Transmit controller: buffers register-file bytes and ALU results, then
// serialises them one byte at a time into a UART transmitter using its Busy handshake.
module tx_ctrl_sys #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     RdData,
  input  logic                      RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
  input  logic                      ALU_OUT_Valid,
  input  logic                      Busy,
  output logic [DATA_WIDTH-1:0]     TX_P_DATA,
  output logic                      TX_DATA_VLD,
  output logic                      CTRL_BUSY,
  output logic                      OVR_ERR
);

  localparam int CNT_W = (BUSY_TIMEOUT < 1) ? 1 : $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    RF_SEND,
    ALU_LSB_SEND,
    ALU_MSB_SEND,
    WAIT_BUSY_HI,
    WAIT_BUSY_LO
  } state_t;

  state_t                    state, state_nxt;
  state_t                    src, src_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt, cnt_inc;
  logic [DATA_WIDTH-1:0]     rf_hold;
  logic [2*DATA_WIDTH-1:0]   alu_hold;
  logic                      rf_pend, alu_pend;
  logic [2*DATA_WIDTH-1:0]   xfer;
  logic                      rf_take, alu_take;
  logic                      rf_ovr, alu_ovr;
  logic                      tx_ld;
  logic [DATA_WIDTH-1:0]     tx_byte;

  assign cnt_inc = cnt + CNT_W'(1);

  // A strobe is an overflow only if the slot stays occupied through this edge.
  assign rf_ovr  = RdData_Valid  && rf_pend  && !rf_take;
  assign alu_ovr = ALU_OUT_Valid && alu_pend && !alu_take;

  assign CTRL_BUSY = (state != IDLE) || rf_pend || alu_pend;

  always_comb begin
    state_nxt = state;
    src_nxt   = src;
    cnt_nxt   = cnt;
    tx_ld     = 1'b0;
    tx_byte   = xfer[DATA_WIDTH-1:0];
    rf_take   = 1'b0;
    alu_take  = 1'b0;
    case (state)
      IDLE: begin
        if (rf_pend) begin
          rf_take   = 1'b1;
          state_nxt = RF_SEND;
        end else if (alu_pend) begin
          alu_take  = 1'b1;
          state_nxt = ALU_LSB_SEND;
        end
      end
      RF_SEND, ALU_LSB_SEND, ALU_MSB_SEND: begin
        if (state == ALU_MSB_SEND) tx_byte = xfer[2*DATA_WIDTH-1:DATA_WIDTH];
        if (!Busy) begin
          tx_ld     = 1'b1;
          src_nxt   = state;
          cnt_nxt   = '0;
          state_nxt = WAIT_BUSY_HI;
        end
      end
      WAIT_BUSY_HI: begin
        if (Busy) begin
          cnt_nxt   = '0;
          state_nxt = WAIT_BUSY_LO;
        end else begin
          cnt_nxt = cnt_inc;
          // UART never acknowledged: resend the same byte, no retry limit.
          if (cnt_inc == CNT_MAX) state_nxt = src;
        end
      end
      WAIT_BUSY_LO: begin
        if (!Busy) state_nxt = (src == ALU_LSB_SEND) ? ALU_MSB_SEND : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      src         <= IDLE;
      cnt         <= '0;
      rf_hold     <= '0;
      alu_hold    <= '0;
      rf_pend     <= 1'b0;
      alu_pend    <= 1'b0;
      xfer        <= '0;
      TX_P_DATA   <= '0;
      TX_DATA_VLD <= 1'b0;
      OVR_ERR     <= 1'b0;
    end else begin
      state <= state_nxt;
      src   <= src_nxt;
      cnt   <= cnt_nxt;

      if (RdData_Valid && !rf_ovr) begin
        rf_hold <= RdData;
        rf_pend <= 1'b1;
      end else if (rf_take) begin
        rf_pend <= 1'b0;
      end

      if (ALU_OUT_Valid && !alu_ovr) begin
        alu_hold <= ALU_OUT;
        alu_pend <= 1'b1;
      end else if (alu_take) begin
        alu_pend <= 1'b0;
      end

      // Snapshot the outgoing word so a same-edge recapture cannot corrupt it.
      if (rf_take) xfer <= {{DATA_WIDTH{1'b0}}, rf_hold};
      else if (alu_take) xfer <= alu_hold;

      TX_DATA_VLD <= tx_ld;
      if (tx_ld) TX_P_DATA <= tx_byte;
      OVR_ERR <= rf_ovr || alu_ovr;
    end
  end

endmodule

// File: tb/tb_tx_ctrl_sys.sv
// Scoreboard bench for tx_ctrl_sys: expected bytes are queued when strobes are
// driven and compared in order whenever the controller emits TX_DATA_VLD.
module tb_tx_ctrl_sys;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RdData = '0;
  logic        RdData_Valid = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_Valid = 1'b0;
  logic        Busy = 1'b0;
  logic [7:0]  TX_P_DATA;
  logic        TX_DATA_VLD;
  logic        CTRL_BUSY;
  logic        OVR_ERR;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  int          vld_cnt = 0;
  int          ovr_cnt = 0;
  int          cyc = 0;
  logic        prev_vld = 1'b0;
  logic        uart_en = 1'b0;
  int          busy_left = 0;
  localparam int BUSY_LEN = 10;

  tx_ctrl_sys #(.DATA_WIDTH(8), .BUSY_TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .RdData(RdData), .RdData_Valid(RdData_Valid),
    .ALU_OUT(ALU_OUT), .ALU_OUT_Valid(ALU_OUT_Valid),
    .Busy(Busy),
    .TX_P_DATA(TX_P_DATA), .TX_DATA_VLD(TX_DATA_VLD),
    .CTRL_BUSY(CTRL_BUSY), .OVR_ERR(OVR_ERR)
  );

  always #5 CLK = ~CLK;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // UART model: Busy rises the cycle after a strobe and stays up BUSY_LEN cycles.
  initial forever begin
    @(negedge CLK);
    if (uart_en) begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) Busy = 1'b0;
      end else if (TX_DATA_VLD) begin
        Busy = 1'b1;
        busy_left = BUSY_LEN;
      end
    end
  end

  // Scoreboard consumer.
  initial forever begin
    logic [7:0] eb;
    @(negedge CLK);
    if (!RST) begin
      if (TX_DATA_VLD) begin
        n_cmp++;
        if (prev_vld) begin
          n_err++;
          $display("FAIL vld_single: TX_DATA_VLD high 2 cycles at cycle %0d, required 1 cycle", cyc);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL tx_byte: got unexpected 0x%02h, required no strobe", TX_P_DATA);
        end else begin
          eb = exp_q.pop_front();
          if (TX_P_DATA !== eb) begin
            n_err++;
            $display("FAIL tx_byte: got 0x%02h, required 0x%02h", TX_P_DATA, eb);
          end
        end
        vld_cnt++;
      end
      if (OVR_ERR) ovr_cnt++;
    end
    prev_vld = TX_DATA_VLD;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input int budget, input string name);
    bit done = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge CLK);
      if (CTRL_BUSY === 1'b0 && Busy === 1'b0) begin
        done = 1;
        break;
      end
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s: CTRL_BUSY=%b after %0d cycles, required 0", name, CTRL_BUSY, budget);
    end
  endtask

  task automatic wait_vld(input int budget, input string name, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge CLK);
      if (TX_DATA_VLD === 1'b1) begin
        at = cyc;
        break;
      end
    end
    n_cmp++;
    if (at < 0) begin
      n_err++;
      $display("FAIL %s: no TX_DATA_VLD within %0d cycles, required a strobe", name, budget);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({TX_P_DATA, TX_DATA_VLD, OVR_ERR, CTRL_BUSY} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got data=%02h vld=%b ovr=%b busy=%b, required all 0",
               TX_P_DATA, TX_DATA_VLD, OVR_ERR, CTRL_BUSY);
    end
    RST = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (CTRL_BUSY !== 1'b0 || TX_DATA_VLD !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got busy=%b vld=%b, required 0 0", CTRL_BUSY, TX_DATA_VLD);
    end
  endtask

  task automatic test_rf_latency();
    uart_en = 1'b1;
    @(negedge CLK);
    RdData = 8'h5A; RdData_Valid = 1'b1; exp_q.push_back(8'h5A);
    @(negedge CLK);
    RdData_Valid = 1'b0;
    n_cmp++;
    if (CTRL_BUSY !== 1'b1) begin
      n_err++; $display("FAIL rf_pending_busy: got %b, required 1", CTRL_BUSY);
    end
    n_cmp++;
    if (TX_DATA_VLD !== 1'b0) begin
      n_err++; $display("FAIL rf_lat_n0: vld got %b, required 0", TX_DATA_VLD);
    end
    @(negedge CLK);
    n_cmp++;
    if (TX_DATA_VLD !== 1'b0) begin
      n_err++; $display("FAIL rf_lat_n1: vld got %b, required 0", TX_DATA_VLD);
    end
    @(negedge CLK);
    n_cmp++;
    if (TX_DATA_VLD !== 1'b1 || TX_P_DATA !== 8'h5A) begin
      n_err++; $display("FAIL rf_lat_n2: got vld=%b data=%02h, required 1 5a", TX_DATA_VLD, TX_P_DATA);
    end
    @(negedge CLK);
    n_cmp++;
    if (TX_DATA_VLD !== 1'b0 || TX_P_DATA !== 8'h5A) begin
      n_err++; $display("FAIL rf_hold_data: got vld=%b data=%02h, required 0 5a", TX_DATA_VLD, TX_P_DATA);
    end
    @(negedge CLK);
    n_cmp++;
    if (CTRL_BUSY !== 1'b1) begin
      n_err++; $display("FAIL rf_busy_during_frame: got %b, required 1", CTRL_BUSY);
    end
    wait_idle(40, "rf_idle");
  endtask

  task automatic test_alu();
    int t1, t2, v0;
    v0 = vld_cnt;
    @(negedge CLK);
    ALU_OUT = 16'h1234; ALU_OUT_Valid = 1'b1;
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    @(negedge CLK);
    ALU_OUT_Valid = 1'b0;
    wait_vld(10, "alu_lsb", t1);
    wait_vld(30, "alu_msb", t2);
    n_cmp++;
    if (t2 - t1 != BUSY_LEN + 2) begin
      n_err++; $display("FAIL alu_msb_gap: got %0d cycles, required %0d", t2 - t1, BUSY_LEN + 2);
    end
    wait_idle(40, "alu_idle");
    n_cmp++;
    if (vld_cnt - v0 != 2) begin
      n_err++; $display("FAIL alu_count: got %0d strobes, required 2", vld_cnt - v0);
    end
  endtask

  task automatic test_simultaneous();
    int v0, o0;
    v0 = vld_cnt; o0 = ovr_cnt;
    @(negedge CLK);
    RdData = 8'hA1; RdData_Valid = 1'b1;
    ALU_OUT = 16'hBEEF; ALU_OUT_Valid = 1'b1;
    exp_q.push_back(8'hA1); exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    @(negedge CLK);
    RdData_Valid = 1'b0; ALU_OUT_Valid = 1'b0;
    wait_idle(100, "simul_idle");
    n_cmp++;
    if (vld_cnt - v0 != 3) begin
      n_err++; $display("FAIL simul_count: got %0d strobes, required 3", vld_cnt - v0);
    end
    n_cmp++;
    if (ovr_cnt != o0) begin
      n_err++; $display("FAIL simul_ovr: got %0d pulses, required 0", ovr_cnt - o0);
    end
  endtask

  task automatic test_overflow();
    int v0, o0;
    v0 = vld_cnt; o0 = ovr_cnt;
    @(negedge CLK);
    ALU_OUT = 16'h5566; ALU_OUT_Valid = 1'b1;
    exp_q.push_back(8'h66); exp_q.push_back(8'h55);
    @(negedge CLK);
    ALU_OUT_Valid = 1'b0;
    repeat (5) @(negedge CLK);
    RdData = 8'h11; RdData_Valid = 1'b1; exp_q.push_back(8'h11);
    @(negedge CLK);
    RdData = 8'h22;
    @(negedge CLK);
    RdData_Valid = 1'b0;
    n_cmp++;
    if (OVR_ERR !== 1'b1) begin
      n_err++; $display("FAIL ovr_pulse: got %b, required 1", OVR_ERR);
    end
    @(negedge CLK);
    n_cmp++;
    if (OVR_ERR !== 1'b0) begin
      n_err++; $display("FAIL ovr_one_cycle: got %b, required 0", OVR_ERR);
    end
    wait_idle(100, "ovr_idle");
    n_cmp++;
    if (vld_cnt - v0 != 3 || ovr_cnt - o0 != 1) begin
      n_err++;
      $display("FAIL ovr_counts: got %0d strobes %0d pulses, required 3 1", vld_cnt - v0, ovr_cnt - o0);
    end
  endtask

  task automatic test_timeout();
    int t1, t2, v0;
    uart_en = 1'b0; Busy = 1'b0;
    v0 = vld_cnt;
    @(negedge CLK);
    RdData = 8'h3C; RdData_Valid = 1'b1;
    exp_q.push_back(8'h3C); exp_q.push_back(8'h3C);
    @(negedge CLK);
    RdData_Valid = 1'b0;
    wait_vld(10, "to_first", t1);
    wait_vld(20, "to_retry", t2);
    n_cmp++;
    if (t2 - t1 != 5) begin
      n_err++; $display("FAIL to_retry_gap: got %0d cycles, required 5", t2 - t1);
    end
    Busy = 1'b1;
    repeat (3) @(negedge CLK);
    Busy = 1'b0;
    wait_idle(20, "to_idle");
    n_cmp++;
    if (vld_cnt - v0 != 2) begin
      n_err++; $display("FAIL to_count: got %0d strobes, required 2", vld_cnt - v0);
    end
    uart_en = 1'b1;
  endtask

  task automatic test_rst_mid();
    int t1, v0;
    @(negedge CLK);
    ALU_OUT = 16'h7788; ALU_OUT_Valid = 1'b1;
    exp_q.push_back(8'h88);
    @(negedge CLK);
    ALU_OUT_Valid = 1'b0;
    wait_vld(10, "rst_lsb", t1);
    @(negedge CLK);
    RST = 1'b1;
    ALU_OUT = 16'hCAFE; ALU_OUT_Valid = 1'b1;
    RdData = 8'h99; RdData_Valid = 1'b1;
    @(negedge CLK);
    RST = 1'b0; ALU_OUT_Valid = 1'b0; RdData_Valid = 1'b0;
    n_cmp++;
    if ({TX_P_DATA, TX_DATA_VLD, OVR_ERR, CTRL_BUSY} !== 11'd0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got data=%02h vld=%b ovr=%b busy=%b, required all 0",
               TX_P_DATA, TX_DATA_VLD, OVR_ERR, CTRL_BUSY);
    end
    v0 = vld_cnt;
    repeat (25) @(negedge CLK);
    n_cmp++;
    if (vld_cnt != v0 || CTRL_BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_abandon: got %0d strobes busy=%b, required 0 0", vld_cnt - v0, CTRL_BUSY);
    end
  endtask

  initial begin
    test_reset();
    test_rf_latency();
    test_alu();
    test_simultaneous();
    test_overflow();
    test_timeout();
    test_rst_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d bytes unsent, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
